// File: rtl/ahb_pkg.sv
// Shared AHB types and constants for the master request controller.
// Transfer encodings, burst/size constants and controller states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HR_OKAY  = 2'b00,
        HR_ERROR = 2'b01,
        HR_RETRY = 2'b10,
        HR_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'b000,
        HB_INCR   = 3'b001,
        HB_WRAP4  = 3'b010,
        HB_INCR4  = 3'b011,
        HB_WRAP8  = 3'b100,
        HB_INCR8  = 3'b101,
        HB_WRAP16 = 3'b110,
        HB_INCR16 = 3'b111
    } hburst_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam hburst_t HBURST_INCR = HB_INCR;
    localparam logic [9:0] KB_BOUNDARY_MASK = 10'h3FF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DRAIN,
        S_RESP2
    } ctrl_state_t;

endpackage

// File: rtl/ahb_master_req_ctrl_if.sv
// AHB master-side bus signals between controller and arbiter/slaves.
// master drives request/address-phase, slave returns grant/ready/resp.
interface ahb_master_req_ctrl_if import ahb_pkg::*; #(
    parameter int ADDR_W = 32
);
    logic              HBUSREQ;
    logic              HLOCK;
    logic              HGRANT;
    logic              HREADY;
    hresp_t            HRESP;
    htrans_t           HTRANS;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    hburst_t           HBURST;
    logic [2:0]        HSIZE;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HADDR,
        output HWRITE, HBURST, HSIZE,
        input  HGRANT, HREADY, HRESP
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HADDR,
        input  HWRITE, HBURST, HSIZE,
        output HGRANT, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_addr_gen.sv
// Burst address and remaining-beat tracker for the AHB master.
// Remembers the beat in data phase so RETRY/SPLIT can rewind to it.
module ahb_addr_gen import ahb_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 5
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [BEAT_W-1:0] load_beats,
    input  logic              accept,
    input  logic              rewind,
    output logic [ADDR_W-1:0] addr,
    output logic [BEAT_W-1:0] rem,
    output logic [ADDR_W-1:0] nxt_addr,
    output logic [BEAT_W-1:0] nxt_rem,
    output logic              nxt_kb
);
    logic [ADDR_W-1:0] fail_addr;
    logic [BEAT_W-1:0] fail_rem;

    assign nxt_addr = addr + ADDR_W'(4);
    assign nxt_rem  = rem - BEAT_W'(1);
    assign nxt_kb   = (nxt_addr[9:0] & KB_BOUNDARY_MASK) == '0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr      <= '0;
            rem       <= '0;
            fail_addr <= '0;
            fail_rem  <= '0;
        end else if (load) begin
            addr <= load_addr;
            rem  <= load_beats;
        end else if (rewind) begin
            addr <= fail_addr;
            rem  <= fail_rem;
        end else if (accept) begin
            // the accepted beat becomes the one in data phase
            fail_addr <= addr;
            fail_rem  <= rem;
            addr      <= nxt_addr;
            rem       <= nxt_rem;
        end
    end
endmodule

// File: rtl/ahb_master_req_ctrl.sv
// AHB master bus-request controller: requests the bus, then issues an
// INCR word burst with wait-state, RETRY/SPLIT and ERROR handling.
module ahb_master_req_ctrl import ahb_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 5
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [BEAT_W-1:0] cmd_beats,
    input  logic              cmd_write,
    input  logic              cmd_lock,
    output logic              done_valid,
    output logic              done_error,
    output logic              beat_strobe,
    ahb_master_req_ctrl_if.master bus
);
    ctrl_state_t       state_q, state_d;
    htrans_t           htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic              hbusreq_q, hbusreq_d;
    logic              hlock_q, hlock_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              derr_q, derr_d;
    logic              stb_q, stb_d;
    logic              dp_q, dp_d;
    logic              wr_q, lock_q;

    logic              load, accept, rewind;
    logic [ADDR_W-1:0] addr, nxt_addr;
    logic [BEAT_W-1:0] rem, nxt_rem;
    logic              nxt_kb;

    logic take, grant, acc, last, lost;
    logic dp_ok, dp_err1, rsp_rs;

    ahb_addr_gen #(
        .ADDR_W (ADDR_W),
        .BEAT_W (BEAT_W)
    ) u_gen (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .load       (load),
        .load_addr  (cmd_addr),
        .load_beats (cmd_beats),
        .accept     (accept),
        .rewind     (rewind),
        .addr       (addr),
        .rem        (rem),
        .nxt_addr   (nxt_addr),
        .nxt_rem    (nxt_rem),
        .nxt_kb     (nxt_kb)
    );

    assign take    = cmd_valid & rdy_q;
    assign grant   = bus.HGRANT & bus.HREADY;
    assign acc     = (state_q == S_ADDR) & bus.HREADY;
    assign last    = nxt_rem == '0;
    assign lost    = ~last & ~bus.HGRANT;
    assign dp_ok   = dp_q & bus.HREADY
                   & (bus.HRESP == HR_OKAY);
    assign dp_err1 = dp_q & ~bus.HREADY
                   & (bus.HRESP != HR_OKAY);
    assign rsp_rs  = (bus.HRESP == HR_RETRY)
                   | (bus.HRESP == HR_SPLIT);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= S_IDLE;
            htrans_q  <= HT_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hbusreq_q <= 1'b0;
            hlock_q   <= 1'b0;
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
            derr_q    <= 1'b0;
            stb_q     <= 1'b0;
            dp_q      <= 1'b0;
            wr_q      <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            htrans_q  <= htrans_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hbusreq_q <= hbusreq_d;
            hlock_q   <= hlock_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
            derr_q    <= derr_d;
            stb_q     <= stb_d;
            dp_q      <= dp_d;
            if (load) begin
                wr_q   <= cmd_write;
                lock_q <= cmd_lock;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (take && cmd_beats != '0)
                    state_d = S_REQ;
            end
            S_REQ: begin
                if (dp_err1)
                    state_d = S_RESP2;
                else if (grant)
                    state_d = S_ADDR;
            end
            S_ADDR: begin
                if (dp_err1)
                    state_d = S_RESP2;
                else if (acc && last)
                    state_d = S_DRAIN;
                else if (acc && lost)
                    state_d = S_REQ;
            end
            S_DRAIN: begin
                if (dp_err1)
                    state_d = S_RESP2;
                else if (dp_ok)
                    state_d = S_IDLE;
            end
            S_RESP2: begin
                if (bus.HREADY)
                    state_d = rsp_rs ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        htrans_d  = htrans_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hbusreq_d = hbusreq_q;
        hlock_d   = hlock_q;
        done_d    = 1'b0;
        derr_d    = 1'b0;
        stb_d     = dp_ok;
        dp_d      = dp_q & ~dp_ok;
        load      = 1'b0;
        accept    = 1'b0;
        rewind    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (take) begin
                    load = 1'b1;
                    if (cmd_beats == '0) begin
                        done_d = 1'b1;
                        derr_d = 1'b1;
                    end else begin
                        hbusreq_d = 1'b1;
                        hlock_d   = cmd_lock;
                    end
                end
            end
            S_REQ: begin
                if (!dp_err1 && grant) begin
                    htrans_d = HT_NONSEQ;
                    haddr_d  = addr;
                    hwrite_d = wr_q;
                    if (rem == BEAT_W'(1)) begin
                        hbusreq_d = 1'b0;
                        hlock_d   = 1'b0;
                    end
                end
            end
            S_ADDR: begin
                if (acc) begin
                    accept = 1'b1;
                    dp_d   = 1'b1;
                    unique case (1'b1)
                        last: htrans_d = HT_IDLE;
                        lost: begin
                            htrans_d  = HT_IDLE;
                            hbusreq_d = 1'b1;
                            hlock_d   = lock_q;
                        end
                        default: begin
                            htrans_d = nxt_kb ? HT_NONSEQ
                                              : HT_SEQ;
                            haddr_d  = nxt_addr;
                            if (nxt_rem == BEAT_W'(1)) begin
                                hbusreq_d = 1'b0;
                                hlock_d   = 1'b0;
                            end
                        end
                    endcase
                end
            end
            S_DRAIN: begin
                if (!dp_err1 && dp_ok)
                    done_d = 1'b1;
            end
            S_RESP2: begin
                if (bus.HREADY) begin
                    dp_d = 1'b0;
                    if (rsp_rs) begin
                        rewind    = 1'b1;
                        hbusreq_d = 1'b1;
                        hlock_d   = lock_q;
                    end else begin
                        hbusreq_d = 1'b0;
                        hlock_d   = 1'b0;
                        done_d    = 1'b1;
                        derr_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // first response cycle cancels the pipelined address
        if (dp_err1)
            htrans_d = HT_IDLE;
        rdy_d = state_d == S_IDLE;
    end

    assign cmd_ready   = rdy_q;
    assign done_valid  = done_q;
    assign done_error  = derr_q;
    assign beat_strobe = stb_q;

    assign bus.HBUSREQ = hbusreq_q;
    assign bus.HLOCK   = hlock_q;
    assign bus.HTRANS  = htrans_q;
    assign bus.HADDR   = haddr_q;
    assign bus.HWRITE  = hwrite_q;
    assign bus.HBURST  = HBURST_INCR;
    assign bus.HSIZE   = HSIZE_WORD;
endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Directed bench for ahb_master_req_ctrl: grant, wait states,
// 1KB crossing, grant loss, RETRY, ERROR, reset and zero beats.
module tb_ahb_master_req_ctrl;
    import ahb_pkg::*;

    logic        HCLK;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [4:0]  cmd_beats;
    logic        cmd_write;
    logic        cmd_lock;
    logic        done_valid;
    logic        done_error;
    logic        beat_strobe;

    ahb_master_req_ctrl_if #(.ADDR_W(32)) bus ();

    ahb_master_req_ctrl #(
        .ADDR_W (32),
        .BEAT_W (5)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_beats   (cmd_beats),
        .cmd_write   (cmd_write),
        .cmd_lock    (cmd_lock),
        .done_valid  (done_valid),
        .done_error  (done_error),
        .beat_strobe (beat_strobe),
        .bus         (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_asrt = 0;
    int n_fail = 0;
    int nstb   = 0;
    int ndone  = 0;

    logic [1:0]  got_t[$];
    logic [31:0] got_a[$];
    logic [1:0]  exp_t[$];
    logic [31:0] exp_a[$];

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, expv);
        end
    endtask

    task automatic tick();
        if ((bus.HTRANS == HT_NONSEQ || bus.HTRANS == HT_SEQ)
            && bus.HREADY) begin
            got_t.push_back(bus.HTRANS);
            got_a.push_back(bus.HADDR);
        end
        @(posedge HCLK);
        #1;
        if (beat_strobe) nstb++;
        if (done_valid) ndone++;
    endtask

    task automatic eb(input logic [1:0] t, input logic [31:0] a);
        exp_t.push_back(t);
        exp_a.push_back(a);
    endtask

    task automatic clr();
        got_t.delete(); got_a.delete();
        exp_t.delete(); exp_a.delete();
        nstb  = 0;
        ndone = 0;
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_n"}, got_t.size(), exp_t.size());
        if (got_t.size() == exp_t.size()) begin
            foreach (exp_t[i]) begin
                chk($sformatf("%s_t%0d", tag, i), got_t[i], exp_t[i]);
                chk($sformatf("%s_a%0d", tag, i), got_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [4:0] b,
                         input logic w, input logic l);
        cmd_addr  = a;
        cmd_beats = b;
        cmd_write = w;
        cmd_lock  = l;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done_valid) seen = 1'b1;
        end
        chk({tag, "_done"}, seen, 1'b1);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_breq"}, bus.HBUSREQ, 1'b0);
        chk({tag, "_lock"}, bus.HLOCK, 1'b0);
        chk({tag, "_trans"}, bus.HTRANS, 2'b00);
        chk({tag, "_addr"}, bus.HADDR, 32'h0);
        chk({tag, "_write"}, bus.HWRITE, 1'b0);
        chk({tag, "_done"}, done_valid, 1'b0);
        chk({tag, "_derr"}, done_error, 1'b0);
        chk({tag, "_stb"}, beat_strobe, 1'b0);
        chk({tag, "_rdy"}, cmd_ready, 1'b0);
    endtask

    initial begin
        HRESET     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_beats  = '0;
        cmd_write  = 1'b0;
        cmd_lock   = 1'b0;
        bus.HGRANT = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = HR_OKAY;

        tick();
        tick();
        chk_rst("rst");
        chk("rst_burst", bus.HBURST, 3'b001);
        chk("rst_size", bus.HSIZE, 3'b010);
        HRESET = 1'b0;
        tick();
        chk("rst_rdy1", cmd_ready, 1'b1);

        // single write, grant on third REQ edge
        clr();
        issue(32'h100, 5'd1, 1'b1, 1'b0);
        chk("s1_rdy0", cmd_ready, 1'b0);
        chk("s1_breq", bus.HBUSREQ, 1'b1);
        chk("s1_lock", bus.HLOCK, 1'b0);
        tick();
        tick();
        chk("s1_wait_tr", bus.HTRANS, 2'b00);
        chk("s1_wait_bq", bus.HBUSREQ, 1'b1);
        bus.HGRANT = 1'b1;
        tick();
        chk("s1_ns", bus.HTRANS, 2'b10);
        chk("s1_addr", bus.HADDR, 32'h100);
        chk("s1_wr", bus.HWRITE, 1'b1);
        chk("s1_bq_low", bus.HBUSREQ, 1'b0);
        tick();
        chk("s1_idle", bus.HTRANS, 2'b00);
        chk("s1_hold", bus.HADDR, 32'h100);
        chk("s1_nostb", beat_strobe, 1'b0);
        tick();
        chk("s1_stb", beat_strobe, 1'b1);
        chk("s1_done", done_valid, 1'b1);
        chk("s1_derr", done_error, 1'b0);
        chk("s1_rdy", cmd_ready, 1'b1);
        eb(2'b10, 32'h100);
        chk_log("s1");
        chk("s1_nstb", nstb, 1);

        // 4-beat locked read, 2 wait states on beat 2
        clr();
        issue(32'h200, 5'd4, 1'b0, 1'b1);
        chk("r4_lock", bus.HLOCK, 1'b1);
        tick();
        chk("r4_ns", bus.HTRANS, 2'b10);
        chk("r4_wr", bus.HWRITE, 1'b0);
        tick();
        chk("r4_a1", bus.HADDR, 32'h204);
        tick();
        chk("r4_a2", bus.HADDR, 32'h208);
        bus.HREADY = 1'b0;
        tick();
        chk("r4_st1_a", bus.HADDR, 32'h208);
        chk("r4_st1_t", bus.HTRANS, 2'b11);
        chk("r4_st1_s", beat_strobe, 1'b0);
        tick();
        chk("r4_st2_a", bus.HADDR, 32'h208);
        bus.HREADY = 1'b1;
        tick();
        chk("r4_a3", bus.HADDR, 32'h20C);
        chk("r4_bq_low", bus.HBUSREQ, 1'b0);
        chk("r4_lk_low", bus.HLOCK, 1'b0);
        wait_done("r4");
        chk("r4_derr", done_error, 1'b0);
        eb(2'b10, 32'h200); eb(2'b11, 32'h204);
        eb(2'b11, 32'h208); eb(2'b11, 32'h20C);
        chk_log("r4");
        chk("r4_nstb", nstb, 4);

        // 1KB boundary crossing
        clr();
        issue(32'h3F8, 5'd4, 1'b1, 1'b0);
        wait_done("kb");
        eb(2'b10, 32'h3F8); eb(2'b11, 32'h3FC);
        eb(2'b10, 32'h400); eb(2'b11, 32'h404);
        chk_log("kb");
        chk("kb_nstb", nstb, 4);

        // grant lost after beat 2 of 6
        clr();
        issue(32'h500, 5'd6, 1'b1, 1'b0);
        tick();
        tick();
        bus.HGRANT = 1'b0;
        tick();
        chk("gl_idle", bus.HTRANS, 2'b00);
        chk("gl_breq", bus.HBUSREQ, 1'b1);
        chk("gl_hold", bus.HADDR, 32'h504);
        tick();
        chk("gl_idle2", bus.HTRANS, 2'b00);
        chk("gl_breq2", bus.HBUSREQ, 1'b1);
        bus.HGRANT = 1'b1;
        tick();
        chk("gl_ns", bus.HTRANS, 2'b10);
        chk("gl_addr", bus.HADDR, 32'h508);
        wait_done("gl");
        chk("gl_derr", done_error, 1'b0);
        eb(2'b10, 32'h500); eb(2'b11, 32'h504);
        eb(2'b10, 32'h508); eb(2'b11, 32'h50C);
        eb(2'b11, 32'h510); eb(2'b11, 32'h514);
        chk_log("gl");
        chk("gl_nstb", nstb, 6);

        // RETRY on beat 3
        clr();
        issue(32'h0, 5'd4, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        chk("rt_pre", bus.HADDR, 32'hC);
        bus.HREADY = 1'b0;
        bus.HRESP  = HR_RETRY;
        tick();
        chk("rt_cancel", bus.HTRANS, 2'b00);
        bus.HREADY = 1'b1;
        tick();
        chk("rt_idle", bus.HTRANS, 2'b00);
        chk("rt_breq", bus.HBUSREQ, 1'b1);
        chk("rt_nodone", done_valid, 1'b0);
        bus.HRESP = HR_OKAY;
        tick();
        chk("rt_ns", bus.HTRANS, 2'b10);
        chk("rt_addr", bus.HADDR, 32'h8);
        wait_done("rt");
        chk("rt_derr", done_error, 1'b0);
        eb(2'b10, 32'h0); eb(2'b11, 32'h4); eb(2'b11, 32'h8);
        eb(2'b10, 32'h8); eb(2'b11, 32'hC);
        chk_log("rt");
        chk("rt_nstb", nstb, 4);

        // ERROR on beat 2
        clr();
        issue(32'h600, 5'd4, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        bus.HREADY = 1'b0;
        bus.HRESP  = HR_ERROR;
        tick();
        chk("er_cancel", bus.HTRANS, 2'b00);
        chk("er_lock1", bus.HLOCK, 1'b1);
        bus.HREADY = 1'b1;
        tick();
        chk("er_done", done_valid, 1'b1);
        chk("er_derr", done_error, 1'b1);
        chk("er_breq", bus.HBUSREQ, 1'b0);
        chk("er_lock", bus.HLOCK, 1'b0);
        chk("er_rdy", cmd_ready, 1'b1);
        bus.HRESP = HR_OKAY;
        tick();
        chk("er_pulse", done_valid, 1'b0);
        eb(2'b10, 32'h600); eb(2'b11, 32'h604);
        chk_log("er");
        chk("er_nstb", nstb, 1);

        // reset mid-burst, then a fresh command
        clr();
        issue(32'h700, 5'd8, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        HRESET = 1'b1;
        tick();
        chk_rst("mr");
        tick();
        chk_rst("mr2");
        HRESET = 1'b0;
        tick();
        chk("mr_rdy", cmd_ready, 1'b1);
        chk("mr_ndone", ndone, 0);
        clr();
        issue(32'h40, 5'd2, 1'b1, 1'b0);
        wait_done("mr");
        chk("mr_derr", done_error, 1'b0);
        eb(2'b10, 32'h40); eb(2'b11, 32'h44);
        chk_log("mr");
        chk("mr_nstb", nstb, 2);

        // zero-beat command
        clr();
        issue(32'h80, 5'd0, 1'b1, 1'b0);
        chk("z_done", done_valid, 1'b1);
        chk("z_derr", done_error, 1'b1);
        chk("z_breq", bus.HBUSREQ, 1'b0);
        chk("z_rdy", cmd_ready, 1'b1);
        tick();
        chk("z_pulse", done_valid, 1'b0);
        chk("z_breq2", bus.HBUSREQ, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_master_req_ctrl.md
Name: ahb_master_req_ctrl

Overview:
- Master-side bus-access controller for the AHB arbiter. It is the requesting end of the HBUSREQx/HLOCKx/HGRANTx handshake.
- Accepts a local burst command (address, beat count, direction, lock) and drives HBUSREQ/HLOCK until granted.
- Once granted, issues the address/control phases as an INCR burst of word transfers, tracking HREADY wait states and HRESP.
- Reports completion or error to the local side; pulses a beat strobe so an external data path can move write/read data.

Parameters:
ADDR_W, 32, address width
BEAT_W, 5, beat-count width (1..16 beats supported; 0 is illegal)

Ports:
HCLK  in  1  bus clock, all logic on rising edge
HRESET  in  1  synchronous, active-high reset
cmd_valid  in  1  local command request
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  ADDR_W  word-aligned start address
cmd_beats  in  BEAT_W  number of beats, 1..16
cmd_write  in  1  1=write, 0=read
cmd_lock  in  1  request locked transfer
done_valid  out  1  one-cycle pulse when command finished
done_error  out  1  qualifies done_valid: burst aborted by ERROR
beat_strobe  out  1  one-cycle pulse per completed data phase (HREADY high, HRESP OKAY)
HBUSREQ  out  1  bus request to arbiter
HLOCK  out  1  lock request to arbiter
HGRANT  in  1  grant from arbiter
HREADY  in  1  transfer-done / bus ready
HRESP  in  2  OKAY=00 ERROR=01 RETRY=10 SPLIT=11
HTRANS  out  2  IDLE=00 NONSEQ=10 SEQ=11
HADDR  out  ADDR_W  address phase
HWRITE  out  1  direction
HBURST  out  3  constant INCR (001)
HSIZE  out  3  constant word (010)

Behaviour:
- All outputs registered. Synchronous reset; while HRESET=1 and the cycle after, outputs are: HBUSREQ=0, HLOCK=0, HTRANS=IDLE, HADDR=0, HWRITE=0, done_valid=0, done_error=0, beat_strobe=0, cmd_ready=0.
- Controller leaves reset in IDLE with cmd_ready=1 from the first non-reset cycle. Reset mid-burst abandons the burst silently: no done_valid.
- States: IDLE, REQ, ADDR, DRAIN, RESP2.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch the command, cmd_ready->0, goto REQ.
  - Next cycle: HBUSREQ=1, HLOCK=cmd_lock.
- REQ:
  - HTRANS=IDLE.
  - Granted when HGRANT=1 and HREADY=1 at a rising edge; goto ADDR.
  - Next cycle: HTRANS=NONSEQ, HADDR=current address, HWRITE=latched.
- ADDR: an address phase is accepted on each edge with HREADY=1.
  - Beat accepted: address+=4, remaining-=1; next HTRANS=SEQ.
  - 1KB boundary: HTRANS=NONSEQ when the new address has bits[9:0]=0.
  - HBUSREQ and HLOCK drop in the cycle the final address phase is driven.
  - After the final accept: HTRANS=IDLE, goto DRAIN.
- Grant lost (HGRANT=0 at an accepting edge, beats remain): the accepted beat stands. Then HTRANS=IDLE, HBUSREQ stays 1, goto REQ. Resume with NONSEQ at the next address.
- DRAIN: waits for the final data phase.
  - HREADY=1 with OKAY: beat_strobe, done_valid=1 with done_error=0, goto IDLE.
- Data-phase tracking: a data phase is pending one cycle behind each accepted address. beat_strobe fires once per OKAY completion, never for IDLE phases. Exactly cmd_beats strobes occur per successful command.
- HRESP≠OKAY with HREADY=0 (first cycle of the two-cycle response): next cycle HTRANS=IDLE (cancels the pipelined address); goto RESP2.
- RESP2 (second response cycle, HREADY=1):
  - ERROR: drop HBUSREQ/HLOCK, done_valid=1 with done_error=1, goto IDLE.
  - RETRY/SPLIT: rewind the address and remaining count to the failed beat, keep HBUSREQ=1, goto REQ. Restart with NONSEQ.
- Under SPLIT, HGRANT stays low until the arbiter unmasks this master. No timeout.
- HADDR and HWRITE hold their value whenever HTRANS=IDLE.
- A command with cmd_beats=0 completes with done_valid and done_error=1 on the next cycle, without ever requesting the bus.

Decomposition:
- Shared package ahb_pkg:
  - htrans_t, hresp_t and hburst_t enums
  - HSIZE_WORD and HBURST_INCR constants
  - KB_BOUNDARY_MASK
  - the controller state enum
- Sub-module ahb_addr_gen:
  - current address/remaining-beat registers
  - increment on accept
  - 1KB-boundary detect
  - rewind to the failed beat on RETRY/SPLIT

Test Plan:
- Single write: cmd_addr=0x100, beats=1, grant after 3 cycles, HREADY=1 -> one NONSEQ@0x100, HBUSREQ low in that cycle, one beat_strobe, done_valid with done_error=0.
- 4-beat read with wait states: addr=0x200, HREADY low 2 cycles on beat 2 -> HADDR 0x200,0x204,0x208,0x20C (NONSEQ,SEQ,SEQ,SEQ); HADDR held during the stall; 4 strobes.
- 1KB crossing: addr=0x3F8, beats=4 -> HTRANS NONSEQ,SEQ,NONSEQ,SEQ at 0x3F8,0x3FC,0x400,0x404.
- Grant removed after beat 2 of 6 -> HTRANS=IDLE, HBUSREQ stays 1; after re-grant, NONSEQ resumes at beat 3's address; 6 strobes total.
- RETRY on beat 3 of addr=0x0 -> IDLE inserted, re-request, restart NONSEQ@0x8. ERROR on beat 2 -> done_error=1 and HBUSREQ=0.
- HRESET=1 mid-burst -> next cycle all outputs at reset values, no done_valid; a fresh command afterwards completes normally.
